// File: rtl/ipsxe_floating_point_rne_share_arb_v1_0.sv
// Round-robin sharing of one rounding APM between several requesters.
// Results return in accept order, tagged with the owning requester.
module ipsxe_floating_point_rne_share_arb_v1_0 #(
    parameter int MAN_WIDTH   = 52,
    parameter int RNE         = 2,
    parameter int RNE1        = 49,
    parameter int NUM_REQ     = 4,
    parameter int APM_LATENCY = 1,
    localparam int DW = MAN_WIDTH + 1 + RNE + RNE1 - 9,
    localparam int RW = MAN_WIDTH + 1 + RNE - 9,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*DW-1:0] i_req_data,
    output logic [NUM_REQ-1:0]    o_req_ready,
    output logic [DW-1:0]         o_apm_din,
    input  logic [RW-1:0]         i_apm_dout,
    output logic [NUM_REQ-1:0]    o_res_valid,
    output logic [RW-1:0]         o_res_data,
    output logic [IW-1:0]         o_res_id,
    output logic                  o_busy
);

    localparam int D = 1 + APM_LATENCY;

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] scan_idx;
    logic          gnt_any;
    logic          accept;
    logic [DW-1:0] din_sel;
    logic [D-1:0]  tag_v;
    logic [IW-1:0] tag_id [D];
    logic          last_v;
    logic [IW-1:0] last_id;

    // First valid index at or after ptr, wrapping at NUM_REQ-1.
    always_comb begin
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_any && i_req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign accept = gnt_any && i_rst_n;

    assign o_req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        din_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IW'(k)) begin
                din_sel = i_req_data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (accept) begin
            if (gnt_idx == IW'(NUM_REQ - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr       <= '0;
            o_apm_din <= '0;
        end else begin
            ptr <= ptr_nxt;
            if (accept) begin
                o_apm_din <= din_sel;
            end
        end
    end

    // Stage 0 lines up with o_apm_din; the last stage with i_apm_dout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_v <= '0;
            for (int s = 0; s < D; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_v[0]  <= accept;
            tag_id[0] <= gnt_idx;
            for (int s = D - 1; s > 0; s--) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    assign last_v  = tag_v[D-1];
    assign last_id = tag_id[D-1];

    assign o_res_valid = last_v ? (NUM_REQ'(1) << last_id) : '0;
    assign o_res_id    = last_v ? last_id : '0;
    assign o_res_data  = last_v ? i_apm_dout : '0;
    assign o_busy      = |tag_v;

endmodule

// File: tb/tb_ipsxe_floating_point_rne_share_arb_v1_0.sv
// Bench for the shared rounding arbiter: four instances, APM_LATENCY 0..3,
// driven with the same stimulus and checked against a cycle-indexed model.
module tb_ipsxe_floating_point_rne_share_arb_v1_0;

    localparam int N    = 4;
    localparam int DW   = 95;
    localparam int RW   = 46;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0][DW-1:0] req_data = '0;

    logic [N-1:0]  rdy  [4];
    logic [DW-1:0] din  [4];
    logic [RW-1:0] dout [4];
    logic [N-1:0]  rv   [4];
    logic [RW-1:0] rd   [4];
    logic [1:0]    rid  [4];
    logic          bsy  [4];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mptr   = 0;

    bit            acc_v    [MAXC];
    int            acc_id   [MAXC];
    logic [DW-1:0] acc_data [MAXC];
    logic [DW-1:0] mdin = '0;

    // APM model: Z + X, i.e. the kept bits plus the round bit.
    function automatic logic [RW-1:0] rnd(input logic [DW-1:0] d);
        return d[DW-1:49] + {{(RW-1){1'b0}}, d[48]};
    endfunction

    for (genvar L = 0; L < 4; L++) begin : g_lat
        ipsxe_floating_point_rne_share_arb_v1_0 #(
            .NUM_REQ     (N),
            .APM_LATENCY (L)
        ) dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_req_valid (req_valid),
            .i_req_data  (req_data),
            .o_req_ready (rdy[L]),
            .o_apm_din   (din[L]),
            .i_apm_dout  (dout[L]),
            .o_res_valid (rv[L]),
            .o_res_data  (rd[L]),
            .o_res_id    (rid[L]),
            .o_busy      (bsy[L])
        );
        if (L == 0) begin : g_comb
            assign dout[L] = rnd(din[L]);
        end else begin : g_seq
            logic [RW-1:0] pipe [3];
            always @(posedge clk) begin
                pipe[0] <= rnd(din[L]);
                for (int k = 1; k < 3; k++) pipe[k] <= pipe[k-1];
            end
            assign dout[L] = pipe[L-1];
        end
    end

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    // Accept cycle whose result is due at cycle c for latency lat.
    function automatic int src(input int lat, input int c);
        int t;
        t = c - 1 - lat;
        if (t >= 0 && acc_v[t]) return t;
        return -1;
    endfunction

    function automatic bit exp_busy(input int lat, input int c);
        for (int t = c - 1 - lat; t < c; t++) begin
            if (t >= 0 && acc_v[t]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) r = {r[N*DW-33:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [N-1:0] rand_valid();
        case ($urandom_range(0, 3))
            0: return 4'($urandom);
            1: return 4'(1) << $urandom_range(0, 3);
            2: return '0;
            default: return '1;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < MAXC; i++) acc_v[i] = 1'b0;
        mptr = 0;
        mdin = '0;
    endtask

    task automatic set_in(input logic [N-1:0] v, input logic [N*DW-1:0] d);
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        #1;
    endtask

    task automatic advance();
        int g;
        g = rst_n ? model_grant(req_valid) : -1;
        if (g >= 0) begin
            acc_v[cyc]    = 1'b1;
            acc_id[cyc]   = g;
            acc_data[cyc] = req_data[2'(g)];
            mptr          = (g + 1) % N;
        end
        @(posedge clk);
        if (g >= 0) mdin = acc_data[cyc];
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        clear_model();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        clear_model();
        #1;
        for (int L = 0; L < 4; L++) begin
            checks++; if (rdy[L] !== '0) begin errors++; $display("FAIL reset_ready L=%0d got %b exp 0", L, rdy[L]); end
            checks++; if (rv[L] !== '0) begin errors++; $display("FAIL reset_res_valid L=%0d got %b exp 0", L, rv[L]); end
            checks++; if (bsy[L] !== 1'b0) begin errors++; $display("FAIL reset_busy L=%0d got %b exp 0", L, bsy[L]); end
            checks++; if (din[L] !== '0) begin errors++; $display("FAIL reset_apm_din L=%0d got %h exp 0", L, din[L]); end
            checks++; if (rd[L] !== '0) begin errors++; $display("FAIL reset_res_data L=%0d got %h exp 0", L, rd[L]); end
            checks++; if (rid[L] !== '0) begin errors++; $display("FAIL reset_res_id L=%0d got %0d exp 0", L, rid[L]); end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_single();
        logic [N*DW-1:0] d;
        logic [DW-1:0] op;
        do_reset();
        d = rand_data();
        op = d[2*DW +: DW];
        set_in(4'b0100, d);
        checks++; if (rdy[1] !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", rdy[1]); end
        advance();
        set_in('0, rand_data());
        checks++; if (bsy[1] !== 1'b1) begin errors++; $display("FAIL single_busy_t1 got %b exp 1", bsy[1]); end
        checks++; if (rv[1] !== 4'b0000) begin errors++; $display("FAIL single_early got %b exp 0000", rv[1]); end
        advance();
        set_in('0, rand_data());
        checks++; if (rv[1] !== 4'b0100) begin errors++; $display("FAIL single_res_valid got %b exp 0100", rv[1]); end
        checks++; if (rid[1] !== 2'd2) begin errors++; $display("FAIL single_res_id got %0d exp 2", rid[1]); end
        checks++; if (bsy[1] !== 1'b1) begin errors++; $display("FAIL single_busy_t2 got %b exp 1", bsy[1]); end
        checks++; if (rd[1] !== rnd(op)) begin errors++; $display("FAIL single_res_data got %h exp %h", rd[1], rnd(op)); end
        advance();
        set_in('0, rand_data());
        checks++; if (bsy[1] !== 1'b0) begin errors++; $display("FAIL single_busy_t3 got %b exp 0", bsy[1]); end
        checks++; if (rv[1] !== 4'b0000 || rid[1] !== 2'd0 || rd[1] !== '0) begin
            errors++; $display("FAIL single_idle_zero got v=%b id=%0d d=%h exp all 0", rv[1], rid[1], rd[1]);
        end
        advance();
    endtask

    task automatic test_rounding();
        logic [N*DW-1:0] d1, d2;
        d1 = '0;
        d1[DW-1:49] = 46'h1;
        d1[48] = 1'b1;
        d1[20] = 1'b1;
        d2 = d1;
        d2[48] = 1'b0;
        do_reset();
        set_in(4'b0001, d1);
        advance();
        set_in(4'b0001, d2);
        advance();
        set_in('0, '0);
        checks++; if (rd[1] !== 46'h2) begin errors++; $display("FAIL round_up got %h exp 2", rd[1]); end
        advance();
        set_in('0, '0);
        checks++; if (rd[1] !== 46'h1) begin errors++; $display("FAIL round_down got %h exp 1", rd[1]); end
        advance();
    endtask

    task automatic test_rr_order();
        do_reset();
        set_in(4'b0010, rand_data());
        checks++; if (rdy[1] !== 4'b0010) begin errors++; $display("FAIL rr_setup got %b exp 0010", rdy[1]); end
        advance();
        set_in(4'b1010, rand_data());
        checks++; if (rdy[1] !== 4'b1000) begin errors++; $display("FAIL rr_first got %b exp 1000", rdy[1]); end
        advance();
        set_in(4'b1010, rand_data());
        checks++; if (rdy[1] !== 4'b0010) begin errors++; $display("FAIL rr_second got %b exp 0010", rdy[1]); end
        advance();
        set_in(4'b1010, rand_data());
        checks++; if (rdy[1] !== 4'b1000) begin errors++; $display("FAIL rr_third got %b exp 1000", rdy[1]); end
        advance();
        set_in('0, '0);
        advance();
        advance();
    endtask

    task automatic test_all_valid();
        logic [N-1:0] e;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_in('1, rand_data());
            e = 4'(1) << (i % 4);
            checks++; if (rdy[1] !== e) begin errors++; $display("FAIL all_grant i=%0d got %b exp %b", i, rdy[1], e); end
            if (i >= 2) begin
                e = 4'(1) << ((i - 2) % 4);
                checks++; if (rv[1] !== e || rid[1] !== 2'((i - 2) % 4)) begin
                    errors++; $display("FAIL all_result i=%0d got v=%b id=%0d exp %b", i, rv[1], rid[1], e);
                end
            end
            advance();
        end
        set_in('0, '0);
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(4'b0011, rand_data());
        advance();
        set_in(4'b0011, rand_data());
        advance();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        clear_model();
        #1;
        for (int L = 0; L < 4; L++) begin
            checks++; if (bsy[L] !== 1'b0 || rv[L] !== '0) begin
                errors++; $display("FAIL mid_reset L=%0d got busy=%b v=%b exp 0", L, bsy[L], rv[L]);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 5; i++) begin
            set_in('0, '0);
            for (int L = 0; L < 4; L++) begin
                checks++; if (rv[L] !== '0) begin errors++; $display("FAIL mid_ghost L=%0d i=%0d got %b exp 0", L, i, rv[L]); end
            end
            advance();
        end
        set_in(4'b1010, rand_data());
        checks++; if (rdy[1] !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got %b exp 0010", rdy[1]); end
        advance();
    endtask

    task automatic test_random_sweep();
        int g, t;
        logic [N-1:0]  er, erv;
        logic [RW-1:0] erd;
        logic [1:0]    eid;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            set_in(rand_valid(), rand_data());
            g = model_grant(req_valid);
            er = (g >= 0) ? 4'(1) << g : '0;
            for (int L = 0; L < 4; L++) begin
                t   = src(L, cyc);
                erv = (t >= 0) ? 4'(1) << acc_id[t] : '0;
                erd = (t >= 0) ? rnd(acc_data[t]) : '0;
                eid = (t >= 0) ? 2'(acc_id[t]) : 2'd0;
                checks++; if (rdy[L] !== er) begin errors++; $display("FAIL rnd_ready L=%0d c=%0d got %b exp %b", L, cyc, rdy[L], er); end
                checks++; if (rv[L] !== erv) begin errors++; $display("FAIL rnd_res_valid L=%0d c=%0d got %b exp %b", L, cyc, rv[L], erv); end
                checks++; if (rid[L] !== eid) begin errors++; $display("FAIL rnd_res_id L=%0d c=%0d got %0d exp %0d", L, cyc, rid[L], eid); end
                checks++; if (rd[L] !== erd) begin errors++; $display("FAIL rnd_res_data L=%0d c=%0d got %h exp %h", L, cyc, rd[L], erd); end
                checks++; if (bsy[L] !== exp_busy(L, cyc)) begin errors++; $display("FAIL rnd_busy L=%0d c=%0d got %b exp %b", L, cyc, bsy[L], exp_busy(L, cyc)); end
                checks++; if (din[L] !== mdin) begin errors++; $display("FAIL rnd_apm_din L=%0d c=%0d got %h exp %h", L, cyc, din[L], mdin); end
            end
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_rr_order();
        test_all_valid();
        test_reset_mid();
        test_random_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
